// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the ID stage and the hazard controller.
//   master : ID stage side. Drives the decoded instruction and branch_taken.
//            Receives stall, id_ex_flush, fwd_a/fwd_b and stall_count.
//   slave  : hazard controller side (the reverse directions).
// Signals:
//   valid_in      ID instruction valid (0 = bubble)
//   rs_in, rt_in  ID source registers
//   rd_in         ID destination register
//   reg_write_in  ID instruction writes rd_in
//   mem_read_in   ID instruction is a load
//   branch_taken  branch resolved taken; squash the ID instruction
//   stall         hold PC and IF/ID this cycle
//   id_ex_flush   clear ID/EX so a bubble enters EX next cycle
//   fwd_a, fwd_b  EX operand sources: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_count   saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
    logic        valid_in;
    logic [4:0]  rs_in;
    logic [4:0]  rt_in;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_read_in;
    logic        branch_taken;
    logic        stall;
    logic        id_ex_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_count;

    modport master (
        output valid_in, rs_in, rt_in, rd_in, reg_write_in, mem_read_in, branch_taken,
        input  stall, id_ex_flush, fwd_a, fwd_b, stall_count
    );

    modport slave (
        input  valid_in, rs_in, rt_in, rd_in, reg_write_in, mem_read_in, branch_taken,
        output stall, id_ex_flush, fwd_a, fwd_b, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard detection and forwarding control for a 5-stage in-order pipeline.
// Keeps a small shadow of the destination registers in EX, MEM and WB.
// Using that shadow it:
//   - detects load-use hazards on the ID instruction (stall + flush),
//   - squashes the ID instruction on a taken branch (flush only),
//   - selects the EX operand forwarding sources one cycle ahead.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  pipeline_hazard_ctrl_if.slave (ID instruction in, controls out)
// stall and id_ex_flush are combinational so they act in the same cycle.
// fwd_a, fwd_b and stall_count are registered.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } slot_t;

    localparam int          EX_IDX    = 0;
    localparam int          MEM_IDX   = 1;
    localparam int          WB_IDX    = 2;
    localparam logic [1:0]  FWD_RF    = 2'b00;
    localparam logic [1:0]  FWD_EXMEM = 2'b01;
    localparam logic [1:0]  FWD_MEMWB = 2'b10;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    // Shadow slots indexed by stage: EX, MEM, WB.
    slot_t       slot_r [0:2];
    logic [1:0]  fwd_a_r;
    logic [1:0]  fwd_b_r;
    logic [15:0] stall_count_r;

    logic        load_use_s;
    logic        stall_s;
    logic        flush_s;
    logic [1:0]  fwd_a_nxt_s;
    logic [1:0]  fwd_b_nxt_s;
    slot_t       id_slot_s;

    // A slot produces register r only if it writes and r is not register 0.
    function automatic logic slot_hit(input slot_t s, input logic [4:0] r);
        return s.wr && (s.rd != 5'd0) && (s.rd == r);
    endfunction

    // Nearer producer wins: the EX-stage producer is newer than the MEM-stage one.
    function automatic logic [1:0] fwd_select(input slot_t ex_s, input slot_t mem_s,
                                              input logic [4:0] r);
        logic [1:0] sel;
        if (slot_hit(ex_s, r)) begin
            sel = FWD_EXMEM;
        end else if (slot_hit(mem_s, r)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Hazard detection, flush/stall decode and next forwarding selection.
    always_comb begin
        load_use_s  = 1'b0;
        stall_s     = 1'b0;
        flush_s     = 1'b0;
        fwd_a_nxt_s = FWD_RF;
        fwd_b_nxt_s = FWD_RF;
        id_slot_s   = '0;

        load_use_s = bus.valid_in && slot_r[EX_IDX].ld &&
                     (slot_hit(slot_r[EX_IDX], bus.rs_in) ||
                      slot_hit(slot_r[EX_IDX], bus.rt_in));

        // Reset forces a bubble into EX and never stalls.
        // A taken branch overrides a load-use stall: the dependent instruction is squashed anyway.
        if (rst) begin
            stall_s = 1'b0;
            flush_s = 1'b1;
        end else begin
            stall_s = load_use_s && !bus.branch_taken;
            flush_s = load_use_s || bus.branch_taken;
        end

        if (flush_s || !bus.valid_in) begin
            id_slot_s   = '0;
            fwd_a_nxt_s = FWD_RF;
            fwd_b_nxt_s = FWD_RF;
        end else begin
            id_slot_s   = '{rd: bus.rd_in, wr: bus.reg_write_in, ld: bus.mem_read_in};
            fwd_a_nxt_s = fwd_select(slot_r[EX_IDX], slot_r[MEM_IDX], bus.rs_in);
            fwd_b_nxt_s = fwd_select(slot_r[EX_IDX], slot_r[MEM_IDX], bus.rt_in);
        end
    end

    // Shadow pipeline shift, registered forwarding selects and the saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                slot_r[i] <= '0;
            end
            fwd_a_r       <= FWD_RF;
            fwd_b_r       <= FWD_RF;
            stall_count_r <= 16'd0;
        end else begin
            slot_r[EX_IDX]  <= id_slot_s;
            // Only EX needs the load flag; downstream slots carry rd/wr only.
            slot_r[MEM_IDX] <= '{rd: slot_r[EX_IDX].rd, wr: slot_r[EX_IDX].wr, ld: 1'b0};
            slot_r[WB_IDX]  <= slot_r[MEM_IDX];
            fwd_a_r         <= fwd_a_nxt_s;
            fwd_b_r         <= fwd_b_nxt_s;
            if (stall_s && (stall_count_r != CNT_MAX)) begin
                stall_count_r <= stall_count_r + 16'd1;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign bus.stall       = stall_s;
    assign bus.id_ex_flush = flush_s;
    assign bus.fwd_a       = fwd_a_r;
    assign bus.fwd_b       = fwd_b_r;
    assign bus.stall_count = stall_count_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Self-checking bench for pipeline_hazard_ctrl.
// The reference model is a history queue of the instructions that entered EX,
// with the newest at the front. The nearest producer is found by searching
// that history. Directed scenarios cover ALU forwarding, distance-2
// forwarding, load-use, register 0, branch priority, saturation and reset.
// A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    pipeline_hazard_ctrl_if bus();

    pipeline_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rd;
        bit         wr;
        bit         ld;
    } ent_t;

    ent_t       hist[$];    // instructions in EX, MEM, WB (front = EX)
    ent_t       pend;       // what enters EX at the next edge
    bit         exp_stall;
    bit         exp_flush;
    logic [1:0] exp_a, exp_b, nx_a, nx_b;
    int         m_count = 0;
    int         n_pass  = 0;
    int         n_total = 0;

    // Newest in-flight producer of r within the two stages ahead of ID: 1 = EX/MEM, 2 = MEM/WB.
    function automatic logic [1:0] producer(input logic [4:0] r);
        for (int k = 0; k < 2; k++) begin
            if (k < hist.size() && hist[k].wr && hist[k].rd != 5'd0 && hist[k].rd == r)
                return 2'(k + 1);
        end
        return 2'b00;
    endfunction

    task automatic drive(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input bit wr, input bit ld, input bit br);
        bit lu;
        bus.valid_in     = v;
        bus.rs_in        = rs;
        bus.rt_in        = rt;
        bus.rd_in        = rd;
        bus.reg_write_in = wr;
        bus.mem_read_in  = ld;
        bus.branch_taken = br;
        lu = 1'b0;
        if (v && hist.size() > 0)
            lu = hist[0].ld && hist[0].wr && hist[0].rd != 5'd0 && (hist[0].rd == rs || hist[0].rd == rt);
        exp_stall = rst ? 1'b0 : (lu && !br);
        exp_flush = rst ? 1'b1 : (lu || br);
        if (exp_flush || !v) begin
            pend = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};
            nx_a = 2'b00;
            nx_b = 2'b00;
        end else begin
            pend = '{rd: rd, wr: wr, ld: ld};
            nx_a = producer(rs);
            nx_b = producer(rt);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            hist.delete();
            for (int k = 0; k < 3; k++) hist.push_back('{rd: 5'd0, wr: 1'b0, ld: 1'b0});
            exp_a   = 2'b00;
            exp_b   = 2'b00;
            m_count = 0;
        end else begin
            hist.push_front(pend);
            if (hist.size() > 3) void'(hist.pop_back());
            exp_a = nx_a;
            exp_b = nx_b;
            if (exp_stall && m_count < 65535) m_count++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        n_total++; if (bus.stall !== 1'b0) $display("FAIL rst_stall got %b want 0", bus.stall); else n_pass++;
        n_total++; if (bus.id_ex_flush !== 1'b1) $display("FAIL rst_flush got %b want 1", bus.id_ex_flush); else n_pass++;
        cycle();
        n_total++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) $display("FAIL rst_fwd got %b/%b want 00/00", bus.fwd_a, bus.fwd_b); else n_pass++;
        n_total++; if (bus.stall_count !== 16'd0) $display("FAIL rst_count got %0d want 0", bus.stall_count); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_alu_chain();
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (bus.stall !== 1'b0) $display("FAIL alu_stall got %b want 0", bus.stall); else n_pass++;
        cycle();
        n_total++; if (bus.fwd_a !== 2'b01) $display("FAIL alu_fwd_a got %b want 01", bus.fwd_a); else n_pass++;
        n_total++; if (bus.fwd_b !== 2'b00) $display("FAIL alu_fwd_b got %b want 00", bus.fwd_b); else n_pass++;
    endtask

    task automatic test_distance2();
        drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b1, 5'd10, 5'd7, 5'd11, 1'b1, 1'b0, 1'b0); cycle();
        n_total++; if (bus.fwd_b !== 2'b10) $display("FAIL dist2_fwd_b got %b want 10", bus.fwd_b); else n_pass++;
        n_total++; if (bus.fwd_a !== 2'b00) $display("FAIL dist2_fwd_a got %b want 00", bus.fwd_a); else n_pass++;
        drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b1, 5'd7, 5'd12, 5'd13, 1'b1, 1'b0, 1'b0); cycle();
        n_total++; if (bus.fwd_a !== 2'b01) $display("FAIL nearer_wins got %b want 01", bus.fwd_a); else n_pass++;
    endtask

    task automatic test_load_use();
        int c0;
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0); cycle();
        c0 = m_count;
        drive(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (bus.stall !== 1'b1) $display("FAIL lu_stall got %b want 1", bus.stall); else n_pass++;
        n_total++; if (bus.id_ex_flush !== 1'b1) $display("FAIL lu_flush got %b want 1", bus.id_ex_flush); else n_pass++;
        cycle();
        n_total++; if (bus.stall_count !== 16'(c0 + 1)) $display("FAIL lu_count got %0d want %0d", bus.stall_count, c0 + 1); else n_pass++;
        n_total++; if (bus.fwd_a !== 2'b00) $display("FAIL lu_bubble_fwd got %b want 00", bus.fwd_a); else n_pass++;
        drive(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (bus.stall !== 1'b0 || bus.id_ex_flush !== 1'b0) $display("FAIL lu_release got %b/%b want 0/0", bus.stall, bus.id_ex_flush); else n_pass++;
        cycle();
        n_total++; if (bus.fwd_a !== 2'b10) $display("FAIL lu_fwd_a got %b want 10", bus.fwd_a); else n_pass++;
    endtask

    task automatic test_reg_zero();
        drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0); cycle();
        drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (bus.stall !== 1'b0) $display("FAIL r0_stall got %b want 0", bus.stall); else n_pass++;
        cycle();
        n_total++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) $display("FAIL r0_fwd got %b/%b want 00/00", bus.fwd_a, bus.fwd_b); else n_pass++;
    endtask

    task automatic test_priority();
        int c0;
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0); cycle();
        c0 = m_count;
        drive(1'b1, 5'd3, 5'd3, 5'd8, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        n_total++; if (bus.stall !== 1'b0) $display("FAIL prio_stall got %b want 0", bus.stall); else n_pass++;
        n_total++; if (bus.id_ex_flush !== 1'b1) $display("FAIL prio_flush got %b want 1", bus.id_ex_flush); else n_pass++;
        cycle();
        n_total++; if (bus.stall_count !== 16'(c0)) $display("FAIL prio_count got %0d want %0d", bus.stall_count, c0); else n_pass++;
        n_total++; if (bus.fwd_a !== 2'b00) $display("FAIL prio_fwd got %b want 00", bus.fwd_a); else n_pass++;
    endtask

    task automatic test_saturation();
        force dut.stall_count_r = 16'hFFFE;
        #1;
        release dut.stall_count_r;
        m_count = 65534;
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0); cycle();
        drive(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0); cycle();
        n_total++; if (bus.stall_count !== 16'hFFFF) $display("FAIL sat_reach got %h want ffff", bus.stall_count); else n_pass++;
        drive(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0); cycle();
        drive(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (bus.stall !== 1'b1) $display("FAIL sat_stall got %b want 1", bus.stall); else n_pass++;
        cycle();
        n_total++; if (bus.stall_count !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", bus.stall_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0); cycle();
        rst = 1'b1;
        drive(1'b1, 5'd3, 5'd5, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (bus.stall !== 1'b0 || bus.id_ex_flush !== 1'b1) $display("FAIL mid_rst_ctl got %b/%b want 0/1", bus.stall, bus.id_ex_flush); else n_pass++;
        cycle();
        n_total++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00 || bus.stall_count !== 16'd0) $display("FAIL mid_rst_out got %b/%b/%0d want 00/00/0", bus.fwd_a, bus.fwd_b, bus.stall_count); else n_pass++;
        rst = 1'b0;
        drive(1'b1, 5'd3, 5'd5, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (bus.stall !== 1'b0) $display("FAIL post_rst_stall got %b want 0", bus.stall); else n_pass++;
        cycle();
        n_total++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) $display("FAIL post_rst_fwd got %b/%b want 00/00", bus.fwd_a, bus.fwd_b); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0);
            @(negedge clk);
            n_total++; if (bus.stall !== exp_stall) $display("FAIL rnd_stall i=%0d got %b want %b", i, bus.stall, exp_stall); else n_pass++;
            n_total++; if (bus.id_ex_flush !== exp_flush) $display("FAIL rnd_flush i=%0d got %b want %b", i, bus.id_ex_flush, exp_flush); else n_pass++;
            cycle();
            n_total++; if (bus.fwd_a !== exp_a) $display("FAIL rnd_fwd_a i=%0d got %b want %b", i, bus.fwd_a, exp_a); else n_pass++;
            n_total++; if (bus.fwd_b !== exp_b) $display("FAIL rnd_fwd_b i=%0d got %b want %b", i, bus.fwd_b, exp_b); else n_pass++;
            n_total++; if (bus.stall_count !== 16'(m_count)) $display("FAIL rnd_count i=%0d got %0d want %0d", i, bus.stall_count, m_count); else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle();
        test_reset();
        test_alu_chain();
        test_distance2();
        test_load_use();
        test_reg_zero();
        test_priority();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached before end of test sequence");
        $fatal(1);
    end
endmodule
